// File: rtl/bft_leaf_rx_depacketizer_pkg.sv
// Shared definitions for the BFT leaf receive depacketizer: packet field
// layout, sizing constants and the credit FSM state encoding.
package bft_leaf_rx_depacketizer_pkg;

  localparam int PACKET_BITS           = 49;
  localparam int PAYLOAD_BITS          = 32;
  localparam int NUM_LEAF_BITS         = 4;
  localparam int NUM_PORT_BITS         = 4;
  localparam int NUM_ADDR_BITS         = 7;
  localparam int NUM_BRAM_ADDR_BITS    = 7;
  localparam int FREESPACE_UPDATE_SIZE = 64;

  localparam int VALID_BIT   = 48;
  localparam int LEAF_MSB    = 47;
  localparam int LEAF_LSB    = 44;
  localparam int PORT_MSB    = 43;
  localparam int PORT_LSB    = 40;
  localparam int SEQ_MSB     = 39;
  localparam int SEQ_LSB     = 33;
  localparam int CTRL_BIT    = 32;
  localparam int PAYLOAD_MSB = 31;

  typedef enum logic [1:0] {
    CR_IDLE   = 2'd0,
    CR_SEND   = 2'd1,
    CR_RESEND = 2'd2
  } credit_state_t;

endpackage

// File: rtl/bft_leaf_rx_depacketizer_fifo.sv
// Synchronous FIFO with a registered head word: the oldest entry is always
// held in head_q so the user sees it one cycle after it was written.
module leaf_rx_fifo #(
  parameter int W  = 32,
  parameter int AW = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         vld_o,
  output logic         full_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]   count_q, count_d, remaining;
  logic [W-1:0]  head_q, head_d;
  logic          vld_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && vld_q;
  assign rdata_o = head_q;
  assign vld_o   = vld_q;

  always_comb begin
    rd_next   = rd_ptr_q + AW'(do_pop);
    remaining = count_q - (AW+1)'(do_pop);
    count_d   = remaining + (AW+1)'(do_push);
    head_d    = head_q;
    // A push into a FIFO that drains to nothing this cycle bypasses memory.
    if (do_push && remaining == '0)
      head_d = wdata_i;
    else if (do_pop && remaining != '0)
      head_d = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_next;
      count_q  <= count_d;
      head_q   <= head_d;
      vld_q    <= (count_d != '0);
    end
  end

endmodule

// File: rtl/bft_leaf_rx_depacketizer.sv
// Leaf endpoint receive path: filters and sequence-checks BFT packets, buffers
// payloads for the user stream and returns freespace credits to the sender.
module bft_leaf_rx_depacketizer
  import bft_leaf_rx_depacketizer_pkg::*;
#(
  parameter int LEAF_ID = 4,
  parameter int PORT_ID = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  input  logic [NUM_LEAF_BITS-1:0] cfg_src_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_src_port,
  output logic [PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  output logic                     vld_interface2user,
  input  logic                     ack_user2interface,
  output logic                     seq_err,
  output logic                     overflow
);

  localparam int CNT_W = $clog2(FREESPACE_UPDATE_SIZE + 1);

  logic [NUM_ADDR_BITS-1:0] exp_seq_q, cseq_q;
  logic [CNT_W-1:0]         popcnt_q;
  logic [1:0]               pend_q;
  logic                     seq_err_q, overflow_q, sent_q;
  logic [PACKET_BITS-1:0]   last_q, dout_q, credit_pkt;
  credit_state_t            state_q;

  logic accept, seq_match, fifo_full, push, pop, credit_req;

  assign accept = din_leaf_bft2interface[VALID_BIT] &&
                  (din_leaf_bft2interface[LEAF_MSB:LEAF_LSB] == NUM_LEAF_BITS'(LEAF_ID)) &&
                  (din_leaf_bft2interface[PORT_MSB:PORT_LSB] == NUM_PORT_BITS'(PORT_ID)) &&
                  !din_leaf_bft2interface[CTRL_BIT];
  assign seq_match  = (din_leaf_bft2interface[SEQ_MSB:SEQ_LSB] == exp_seq_q);
  assign push       = accept && seq_match && !fifo_full;
  assign pop        = vld_interface2user && ack_user2interface;
  assign credit_req = pop && (popcnt_q == CNT_W'(FREESPACE_UPDATE_SIZE - 1));
  assign credit_pkt = {1'b1, cfg_src_leaf, cfg_src_port, cseq_q, 1'b1,
                       PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};

  leaf_rx_fifo #(
    .W  (PAYLOAD_BITS),
    .AW (NUM_BRAM_ADDR_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (din_leaf_bft2interface[PAYLOAD_MSB:0]),
    .pop_i   (pop),
    .rdata_o (dout_leaf_interface2user),
    .vld_o   (vld_interface2user),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_seq_q  <= '0;
      popcnt_q   <= '0;
      seq_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) exp_seq_q <= exp_seq_q + 1'b1;
      if (accept && !seq_match) seq_err_q <= 1'b1;
      if (accept && seq_match && fifo_full) overflow_q <= 1'b1;
      if (credit_req) popcnt_q <= '0;
      else if (pop) popcnt_q <= popcnt_q + 1'b1;
    end
  end

  // Credit FSM: dout is driven only while in SEND or RESEND. A request seen
  // while busy is banked in pend_q so none is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CR_IDLE;
      pend_q  <= '0;
      cseq_q  <= '0;
      sent_q  <= 1'b0;
      last_q  <= '0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        CR_IDLE: begin
          if (credit_req || pend_q != 2'd0) begin
            state_q <= CR_SEND;
            dout_q  <= credit_pkt;
            last_q  <= credit_pkt;
            cseq_q  <= cseq_q + 1'b1;
            sent_q  <= 1'b1;
            pend_q  <= pend_q + {1'b0, credit_req} - 2'd1;
          end else if (resend && sent_q) begin
            state_q <= CR_RESEND;
            dout_q  <= last_q;
          end else begin
            dout_q <= '0;
          end
        end
        default: begin
          state_q <= CR_IDLE;
          dout_q  <= '0;
          if (credit_req && pend_q != 2'd2) pend_q <= pend_q + 2'd1;
        end
      endcase
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign seq_err                 = seq_err_q;
  assign overflow                = overflow_q;

endmodule

// File: tb/tb_bft_leaf_rx_depacketizer.sv
// Self-checking bench for bft_leaf_rx_depacketizer: randomized traffic against
// a queue-based reference model of the receive buffer and credit return.
module tb_bft_leaf_rx_depacketizer;

  logic        clk;
  logic        reset;
  logic [48:0] din;
  logic [48:0] dout_bft;
  logic        resend;
  logic [3:0]  cfg_leaf;
  logic [3:0]  cfg_port;
  logic [31:0] dout_user;
  logic        vld;
  logic        ack;
  logic        seq_err;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [48:0] cr_exp_q[$];
  logic [48:0] cr_obs_q[$];
  int          m_exp_seq, m_pop_cnt, m_cseq;
  bit          m_sent, m_seq_err, m_ovf;
  logic [48:0] m_last;

  bft_leaf_rx_depacketizer dut (
    .clk                      (clk),
    .reset                    (reset),
    .din_leaf_bft2interface   (din),
    .dout_leaf_interface2bft  (dout_bft),
    .resend                   (resend),
    .cfg_src_leaf             (cfg_leaf),
    .cfg_src_port             (cfg_port),
    .dout_leaf_interface2user (dout_user),
    .vld_interface2user       (vld),
    .ack_user2interface       (ack),
    .seq_err                  (seq_err),
    .overflow                 (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (vld && ack) obs_q.push_back(dout_user);
      if (dout_bft != 49'd0) cr_obs_q.push_back(dout_bft);
    end
  end

  function automatic logic [48:0] mk(input int leaf, input int port, input int seq,
                                     input int ctrl, input logic [31:0] pl);
    logic [48:0] p;
    p = {1'b1, 4'(leaf), 4'(port), 7'(seq), 1'(ctrl), pl};
    return p;
  endfunction

  function automatic logic [48:0] credit(input int seq);
    logic [48:0] p;
    p = {1'b1, 4'd3, 4'd2, 7'(seq), 1'b1, 32'd64};
    return p;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_exp_seq = 0;
    m_pop_cnt = 0;
    m_cseq    = 0;
    m_sent    = 0;
    m_seq_err = 0;
    m_ovf     = 0;
    m_last    = '0;
  endtask

  // Apply one cycle of inputs and advance the reference model by the same cycle.
  task automatic step(input logic [48:0] pkt, input logic a, input logic rs);
    bit pop, full, acc, req;
    int seq;
    logic [48:0] cp;
    din = pkt; ack = a; resend = rs;
    pop  = (m_q.size() != 0) && a;
    full = (m_q.size() >= 128);
    acc  = pkt[48] && (pkt[47:44] == 4'd4) && (pkt[43:40] == 4'd1) && !pkt[32];
    seq  = int'(pkt[39:33]);
    req  = 0;
    if (pop) begin
      exp_q.push_back(m_q.pop_front());
      m_pop_cnt++;
      if (m_pop_cnt == 64) begin m_pop_cnt = 0; req = 1; end
    end
    if (acc) begin
      if (seq != m_exp_seq) m_seq_err = 1;
      else if (full) m_ovf = 1;
      else begin m_q.push_back(pkt[31:0]); m_exp_seq = (m_exp_seq + 1) % 128; end
    end
    if (req) begin
      cp = {1'b1, cfg_leaf, cfg_port, 7'(m_cseq), 1'b1, 32'd64};
      cr_exp_q.push_back(cp);
      m_last = cp; m_sent = 1; m_cseq = (m_cseq + 1) % 128;
    end else if (rs && m_sent) begin
      cr_exp_q.push_back(m_last);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; din = '0; ack = 1'b0; resend = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; din = '0; ack = 1'b0; resend = 1'b0;
    model_clear();
    #3;
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b want=0", vld); end
    total++; if (dout_user !== 32'd0) begin bad++; $display("FAIL reset_user got=%h want=0", dout_user); end
    total++; if (dout_bft !== 49'd0) begin bad++; $display("FAIL reset_bft got=%h want=0", dout_bft); end
    total++; if ({seq_err, overflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {seq_err, overflow}); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int n0, nc;
    n0 = obs_q.size(); nc = cr_obs_q.size();
    step(mk(4, 1, 0, 0, 32'hA0), 1'b1, 1'b0);
    total++; if (vld !== 1'b1 || dout_user !== 32'hA0) begin bad++; $display("FAIL single_latency got vld=%0b data=%h want vld=1 data=a0", vld, dout_user); end
    for (int i = 1; i < 4; i++) step(mk(4, 1, i, 0, 32'hA0 + 32'(i)), 1'b1, 1'b0);
    repeat (4) step(49'd0, 1'b1, 1'b0);
    total++; if (obs_q.size() - n0 != 4) begin bad++; $display("FAIL single_count got=%0d want=4", obs_q.size() - n0); end
    for (int i = 0; i < 4; i++) begin
      total++; if (obs_q[n0+i] !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL single_word%0d got=%h want=%h", i, obs_q[n0+i], 32'hA0 + 32'(i)); end
    end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL single_empty got vld=%0b want=0", vld); end
    total++; if (cr_obs_q.size() != nc) begin bad++; $display("FAIL single_no_credit got=%0d want=%0d", cr_obs_q.size(), nc); end
  endtask

  task automatic test_filter();
    logic [31:0] w;
    step(mk(5, 1, 4, 0, $urandom), 1'b0, 1'b0);
    step(mk(4, 1, 4, 1, $urandom), 1'b0, 1'b0);
    total++; if (vld !== 1'b0 || seq_err !== 1'b0) begin bad++; $display("FAIL filter_ignore got vld=%0b seq_err=%0b want 0 0", vld, seq_err); end
    step(mk(4, 1, 7, 0, $urandom), 1'b0, 1'b0);
    total++; if (vld !== 1'b0 || seq_err !== 1'b1) begin bad++; $display("FAIL filter_seqerr got vld=%0b seq_err=%0b want 0 1", vld, seq_err); end
    w = $urandom;
    step(mk(4, 1, 4, 0, w), 1'b0, 1'b0);
    total++; if (vld !== 1'b1 || dout_user !== w) begin bad++; $display("FAIL filter_accept got vld=%0b data=%h want 1 %h", vld, dout_user, w); end
    repeat (3) step(49'd0, 1'b1, 1'b0);
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL filter_drain got vld=%0b want=0", vld); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3];
    int n0;
    for (int k = 0; k < 3; k++) begin
      w[k] = $urandom;
      step(mk(4, 1, m_exp_seq, 0, w[k]), 1'b0, 1'b0);
    end
    n0 = obs_q.size();
    total++; if (vld !== 1'b1 || dout_user !== w[0]) begin bad++; $display("FAIL bp_head got vld=%0b data=%h want 1 %h", vld, dout_user, w[0]); end
    step(49'd0, 1'b1, 1'b0);
    step(49'd0, 1'b0, 1'b0);
    total++; if (dout_user !== w[1]) begin bad++; $display("FAIL bp_hold1 got=%h want=%h", dout_user, w[1]); end
    step(49'd0, 1'b0, 1'b0);
    total++; if (vld !== 1'b1 || dout_user !== w[1]) begin bad++; $display("FAIL bp_hold2 got vld=%0b data=%h want 1 %h", vld, dout_user, w[1]); end
    step(49'd0, 1'b1, 1'b0);
    total++; if (obs_q.size() - n0 != 2) begin bad++; $display("FAIL bp_transfers got=%0d want=2", obs_q.size() - n0); end
    total++; if (obs_q[n0] !== w[0] || obs_q[n0+1] !== w[1]) begin bad++; $display("FAIL bp_order got=%h,%h want=%h,%h", obs_q[n0], obs_q[n0+1], w[0], w[1]); end
    repeat (3) step(49'd0, 1'b1, 1'b0);
  endtask

  task automatic test_credit();
    int nc;
    do_reset();
    nc = cr_obs_q.size();
    for (int i = 0; i < 128; i++)
      step(mk(4, 1, i, 0, $urandom), 1'($urandom_range(0, 1)), 1'b0);
    repeat (140) step(49'd0, 1'b1, 1'b0);
    total++; if (cr_obs_q.size() - nc != 2) begin bad++; $display("FAIL credit_count got=%0d want=2", cr_obs_q.size() - nc); end
    total++; if (cr_obs_q[nc] !== credit(0)) begin bad++; $display("FAIL credit_first got=%h want=%h", cr_obs_q[nc], credit(0)); end
    total++; if (cr_obs_q[nc+1] !== credit(1)) begin bad++; $display("FAIL credit_second got=%h want=%h", cr_obs_q[nc+1], credit(1)); end
  endtask

  task automatic test_resend();
    int nc;
    nc = cr_obs_q.size();
    step(49'd0, 1'b0, 1'b1);
    repeat (4) step(49'd0, 1'b0, 1'b0);
    total++; if (cr_obs_q.size() - nc != 1) begin bad++; $display("FAIL resend_count got=%0d want=1", cr_obs_q.size() - nc); end
    total++; if (cr_obs_q[nc] !== credit(1)) begin bad++; $display("FAIL resend_pkt got=%h want=%h", cr_obs_q[nc], credit(1)); end
    for (int i = 0; i < 64; i++) step(mk(4, 1, m_exp_seq, 0, $urandom), 1'b0, 1'b0);
    nc = cr_obs_q.size();
    repeat (63) step(49'd0, 1'b1, 1'b0);
    step(49'd0, 1'b1, 1'b1);
    repeat (5) step(49'd0, 1'b1, 1'b0);
    total++; if (cr_obs_q.size() - nc != 1) begin bad++; $display("FAIL collide_count got=%0d want=1", cr_obs_q.size() - nc); end
    total++; if (cr_obs_q[nc] !== credit(2)) begin bad++; $display("FAIL collide_pkt got=%h want=%h", cr_obs_q[nc], credit(2)); end
  endtask

  task automatic test_full();
    int n0;
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 129; i++) step(mk(4, 1, i % 128, 0, $urandom), 1'b0, 1'b0);
    total++; if (overflow !== 1'b1 || seq_err !== 1'b0) begin bad++; $display("FAIL full_flags got ovf=%0b seq_err=%0b want 1 0", overflow, seq_err); end
    n0 = obs_q.size();
    repeat (135) step(49'd0, 1'b1, 1'b0);
    total++; if (obs_q.size() - n0 != 128) begin bad++; $display("FAIL full_drain got=%0d want=128", obs_q.size() - n0); end
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL full_empty got vld=%0b want=0", vld); end
    w = $urandom;
    step(mk(4, 1, 0, 0, w), 1'b0, 1'b0);
    total++; if (vld !== 1'b1 || dout_user !== w) begin bad++; $display("FAIL full_wrap got vld=%0b data=%h want 1 %h", vld, dout_user, w); end
    repeat (2) step(49'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) step(mk(4, 1, m_exp_seq, 0, $urandom), 1'b0, 1'b0);
    total++; if (vld !== 1'b1) begin bad++; $display("FAIL mid_buffered got vld=%0b want=1", vld); end
    #2 reset = 1'b0;
    #1;
    total++; if (vld !== 1'b0 || dout_user !== 32'd0 || dout_bft !== 49'd0) begin bad++; $display("FAIL mid_async got vld=%0b user=%h bft=%h want all 0", vld, dout_user, dout_bft); end
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) step(49'd0, 1'b1, 1'b0);
    total++; if (vld !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL mid_after got vld=%0b ovf=%0b want 0 0", vld, overflow); end
  endtask

  task automatic test_scoreboard();
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL sb_words got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL sb_word%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (cr_obs_q.size() != cr_exp_q.size()) begin bad++; $display("FAIL sb_credits got=%0d want=%0d", cr_obs_q.size(), cr_exp_q.size()); end
    for (int i = 0; i < cr_exp_q.size() && i < cr_obs_q.size(); i++) begin
      total++; if (cr_obs_q[i] !== cr_exp_q[i]) begin bad++; $display("FAIL sb_credit%0d got=%h want=%h", i, cr_obs_q[i], cr_exp_q[i]); end
    end
    total++; if (seq_err !== m_seq_err || overflow !== m_ovf) begin bad++; $display("FAIL sb_flags got=%0b%0b want=%0b%0b", seq_err, overflow, m_seq_err, m_ovf); end
  endtask

  initial begin
    cfg_leaf = 4'd3;
    cfg_port = 4'd2;
    reset = 1'b1; din = '0; ack = 1'b0; resend = 1'b0;
    test_reset();
    test_single();
    test_filter();
    test_backpressure();
    test_credit();
    test_resend();
    test_full();
    test_reset_mid();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
